// File: rtl/ptc_lock_ctrl_pkg.sv
// Shared types and default parameters for the FMDLL phase-tracking lock controller.
package ptc_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    TRACK  = 2'd2,
    HOLD   = 2'd3
  } ptc_state_e;

  localparam int PTC_WIDTH      = 10;
  localparam int PTC_SETTLE     = 4;
  localparam int PTC_LOSS_LIMIT = 4;
endpackage

// File: rtl/ptc_lock_ctrl_if.sv
// Phase-detector / delay-line side of the lock controller.
interface ptc_lock_ctrl_if
  import ptc_pkg::*;
#(
  parameter int WIDTH = PTC_WIDTH
);
  logic             start;
  logic             track_en;
  logic             comp;
  logic [WIDTH-1:0] code;
  logic             pd_rst;
  logic             busy;
  logic             locked;
  logic             done;
  logic             relock;

  modport master (output start, track_en, comp,
                  input  code, pd_rst, busy, locked, done, relock);
  modport slave  (input  start, track_en, comp,
                  output code, pd_rst, busy, locked, done, relock);
endinterface

// File: rtl/ptc_settle_timer.sv
// Modulo-SETTLE trial timer; parked at cycle 0 whenever the loop is not running.
module ptc_settle_timer
  import ptc_pkg::*;
#(
  parameter int SETTLE = PTC_SETTLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic trial_start,
  output logic trial_end
);
  localparam int CW = $clog2(SETTLE);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                cnt <= '0;
    else if (!run || cnt == CW'(SETTLE - 1))   cnt <= '0;
    else                                       cnt <= cnt + 1'b1;
  end

  assign trial_start = run && (cnt == '0);
  assign trial_end   = run && (cnt == CW'(SETTLE - 1));
endmodule

// File: rtl/ptc_lock_ctrl.sv
// SAR search plus +/-1 tracking lock controller with loss-of-lock re-search.
module ptc_lock_ctrl
  import ptc_pkg::*;
#(
  parameter int WIDTH      = PTC_WIDTH,
  parameter int SETTLE     = PTC_SETTLE,
  parameter int LOSS_LIMIT = PTC_LOSS_LIMIT
) (
  input  logic             CLK_exit,
  input  logic             rst_n,
  ptc_lock_ctrl_if.slave   bus
);
  localparam int BW = $clog2(WIDTH);
  localparam int RW = $clog2(LOSS_LIMIT + 1);
  localparam logic [WIDTH-1:0] MID = WIDTH'(1) << (WIDTH - 1);

  ptc_state_e       state;
  logic [WIDTH-1:0] code_q;
  logic             pd_rst_q, busy_q, locked_q, done_q, relock_q;
  logic [BW-1:0]    bit_idx;
  logic [RW-1:0]    run;
  logic             dir;
  logic             start_q;
  logic             trial_start, trial_end;

  ptc_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk         (CLK_exit),
    .rst_n       (rst_n),
    .run         (state == SEARCH || state == TRACK),
    .trial_start (trial_start),
    .trial_end   (trial_end)
  );

  // SAR: decide the current bit, then trial the next lower one (none after bit 0).
  logic [WIDTH-1:0] sar_mask, code_sar, code_step;
  logic [RW-1:0]    run_nxt;
  logic             loss;

  assign sar_mask  = WIDTH'(1) << bit_idx;
  assign code_sar  = (bus.comp ? code_q : (code_q & ~sar_mask)) | (sar_mask >> 1);
  assign code_step = bus.comp ? ((&code_q)      ? code_q : code_q + 1'b1)
                              : ((code_q == '0) ? code_q : code_q - 1'b1);
  // A saturated step still counts toward the run in its direction.
  assign run_nxt   = (run == '0 || dir == bus.comp) ? run + 1'b1 : RW'(1);
  assign loss      = (run_nxt == RW'(LOSS_LIMIT));

  always_ff @(posedge CLK_exit or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      code_q   <= '0;
      pd_rst_q <= 1'b1;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
      relock_q <= 1'b0;
      bit_idx  <= '0;
      run      <= '0;
      dir      <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      start_q  <= bus.start;
      done_q   <= 1'b0;
      relock_q <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          pd_rst_q <= 1'b1;
          if (start_q) begin
            state    <= SEARCH;
            code_q   <= MID;
            bit_idx  <= BW'(WIDTH - 1);
            busy_q   <= 1'b1;
            locked_q <= 1'b0;
            run      <= '0;
          end
        end
        SEARCH: begin
          if (trial_end) begin
            pd_rst_q <= 1'b1;
            code_q   <= code_sar;
            if (bit_idx == '0) begin
              done_q   <= 1'b1;
              locked_q <= 1'b1;
              busy_q   <= 1'b0;
              run      <= '0;
              state    <= bus.track_en ? TRACK : HOLD;
            end else begin
              bit_idx <= bit_idx - 1'b1;
            end
          end else if (trial_start) begin
            pd_rst_q <= 1'b0;
          end
        end
        TRACK: begin
          if (trial_end) begin
            pd_rst_q <= 1'b1;
            if (loss || start_q) begin
              relock_q <= loss;
              locked_q <= 1'b0;
              state    <= SEARCH;
              code_q   <= MID;
              bit_idx  <= BW'(WIDTH - 1);
              busy_q   <= 1'b1;
              run      <= '0;
            end else if (!bus.track_en) begin
              state <= HOLD;
              run   <= '0;
            end else begin
              code_q <= code_step;
              run    <= run_nxt;
              dir    <= bus.comp;
            end
          end else if (trial_start) begin
            pd_rst_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.code   = code_q;
  assign bus.pd_rst = pd_rst_q;
  assign bus.busy   = busy_q;
  assign bus.locked = locked_q;
  assign bus.done   = done_q;
  assign bus.relock = relock_q;
endmodule
